// File: rtl/maxpool_layer.sv
// Max-pools each non-overlapping POOL_DIM x POOL_DIM window of the conv output into a local buffer.
// Latency 2*POOL_DIM^2+1 cycles per output; src_valid only gates the start, never stalls a pass.
module maxpool_layer #(
    parameter int NUM_CHANNELS = 1,
    parameter int INPUT_DIM    = 4,
    parameter int POOL_DIM     = 2,
    parameter int OUTPUT_DIM   = INPUT_DIM / POOL_DIM,
    parameter int DATA_SIZE    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 src_valid,
    output logic [15:0]          src_idx_e,
    output logic [15:0]          src_idx_y,
    output logic [15:0]          src_idx_x,
    input  logic [DATA_SIZE-1:0] src_data,
    input  logic [15:0]          rd_idx_e,
    input  logic [15:0]          rd_idx_y,
    input  logic [15:0]          rd_idx_x,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 done
);
    localparam int NUM_OUT = NUM_CHANNELS * OUTPUT_DIM * OUTPUT_DIM;
    localparam int ODSQ    = OUTPUT_DIM * OUTPUT_DIM;
    localparam int AW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int EXP_W   = (DATA_SIZE == 32) ? 8 : 11;
    localparam int MAN_W   = DATA_SIZE - 1 - EXP_W;

    localparam logic [15:0] K_LAST = 16'(POOL_DIM - 1);
    localparam logic [15:0] O_LAST = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0] C_LAST = 16'(NUM_CHANNELS - 1);
    localparam logic [15:0] POOL16 = 16'(POOL_DIM);
    localparam logic [15:0] OD16   = 16'(OUTPUT_DIM);
    localparam logic [15:0] NC16   = 16'(NUM_CHANNELS);

    typedef enum logic [2:0] {IDLE, ISSUE, ACCUM, WRITE, DONE} state_t;

    // Strict IEEE greater-than on raw bits: NaN on either side and +0/-0 compare false.
    function automatic logic fp_gt(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
        logic a_nan;
        logic b_nan;
        logic [DATA_SIZE-2:0] am;
        logic [DATA_SIZE-2:0] bm;
        am    = a[DATA_SIZE-2:0];
        bm    = b[DATA_SIZE-2:0];
        a_nan = (&a[DATA_SIZE-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan = (&b[DATA_SIZE-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        fp_gt = 1'b0;
        if (a_nan || b_nan)
            fp_gt = 1'b0;
        else if ((am == '0) && (bm == '0))
            fp_gt = 1'b0;
        else if (!a[DATA_SIZE-1] && b[DATA_SIZE-1])
            fp_gt = 1'b1;
        else if (a[DATA_SIZE-1] && !b[DATA_SIZE-1])
            fp_gt = 1'b0;
        else if (!a[DATA_SIZE-1])
            fp_gt = (am > bm);
        else
            fp_gt = (am < bm);
    endfunction

    state_t               state_q, state_d;
    logic [15:0]          ch_q, ch_d, oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [15:0]          idx_e_q, idx_y_q, idx_x_q;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [DATA_SIZE-1:0] pool_q [NUM_OUT];
    logic                 win_last, out_last;
    logic [AW-1:0]        wr_addr, rd_addr;
    logic                 rd_hit;

    assign win_last = (ky_q == K_LAST) && (kx_q == K_LAST);
    assign out_last = (ch_q == C_LAST) && (oy_q == O_LAST) && (ox_q == O_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            acc_q   <= '0;
            idx_e_q <= '0;
            idx_y_q <= '0;
            idx_x_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (state_q == ISSUE) begin
                idx_e_q <= src_idx_e;
                idx_y_q <= src_idx_y;
                idx_x_q <= src_idx_x;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && src_valid) state_d = ISSUE;
            ISSUE:   state_d = ACCUM;
            ACCUM:   state_d = win_last ? WRITE : ISSUE;
            WRITE:   state_d = out_last ? DONE : ISSUE;
            DONE:    if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_d  = ch_q;
        oy_d  = oy_q;
        ox_d  = ox_q;
        ky_d  = ky_q;
        kx_d  = kx_q;
        acc_d = acc_q;
        case (state_q)
            IDLE: begin
                if (state_d == ISSUE) begin
                    ch_d = '0;
                    oy_d = '0;
                    ox_d = '0;
                    ky_d = '0;
                    kx_d = '0;
                end
            end
            ACCUM: begin
                // First element is a plain load so all-negative windows pool correctly.
                if (((ky_q == '0) && (kx_q == '0)) || fp_gt(src_data, acc_q))
                    acc_d = src_data;
                if (kx_q == K_LAST) begin
                    kx_d = '0;
                    ky_d = (ky_q == K_LAST) ? 16'd0 : ky_q + 16'd1;
                end else begin
                    kx_d = kx_q + 16'd1;
                end
            end
            WRITE: begin
                if (ox_q == O_LAST) begin
                    ox_d = '0;
                    if (oy_q == O_LAST) begin
                        oy_d = '0;
                        ch_d = (ch_q == C_LAST) ? 16'd0 : ch_q + 16'd1;
                    end else begin
                        oy_d = oy_q + 16'd1;
                    end
                end else begin
                    ox_d = ox_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d    = (state_d == ISSUE) || (state_d == ACCUM) || (state_d == WRITE);
        done_d    = (state_q == DONE) && (state_d == DONE);
        src_idx_e = idx_e_q;
        src_idx_y = idx_y_q;
        src_idx_x = idx_x_q;
        if (state_q == ISSUE) begin
            src_idx_e = ch_q;
            src_idx_y = oy_q * POOL16 + ky_q;
            src_idx_x = ox_q * POOL16 + kx_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    assign wr_addr = AW'({16'd0, ch_q} * ODSQ + {16'd0, oy_q} * OUTPUT_DIM + {16'd0, ox_q});
    assign rd_addr = AW'({16'd0, rd_idx_e} * ODSQ + {16'd0, rd_idx_y} * OUTPUT_DIM + {16'd0, rd_idx_x});
    assign rd_hit  = (rd_idx_e < NC16) && (rd_idx_y < OD16) && (rd_idx_x < OD16);
    assign rd_data = rd_hit ? pool_q[rd_addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) pool_q[i] <= '0;
        end else if (state_q == WRITE) begin
            pool_q[wr_addr] <= acc_q;
        end
    end
endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: a 1ch/4x4 instance and a 2ch/5x5 instance.
module tb_maxpool_layer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_valid, a_busy, a_done;
    logic [15:0] a_idx_e, a_idx_y, a_idx_x, a_rd_e, a_rd_y, a_rd_x;
    logic [63:0] a_src_data, a_rd_data;
    logic        b_start, b_valid, b_busy, b_done;
    logic [15:0] b_idx_e, b_idx_y, b_idx_x, b_rd_e, b_rd_y, b_rd_x;
    logic [63:0] b_src_data, b_rd_data;

    logic [63:0] mem_a [16];
    logic [63:0] mem_b [50];
    logic        b_edge_hit = 1'b0;

    int errors = 0;
    int checks = 0;
    int lat;

    maxpool_layer #(.NUM_CHANNELS(1), .INPUT_DIM(4), .POOL_DIM(2), .DATA_SIZE(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .src_valid(a_valid),
        .src_idx_e(a_idx_e), .src_idx_y(a_idx_y), .src_idx_x(a_idx_x), .src_data(a_src_data),
        .rd_idx_e(a_rd_e), .rd_idx_y(a_rd_y), .rd_idx_x(a_rd_x), .rd_data(a_rd_data),
        .busy(a_busy), .done(a_done)
    );

    maxpool_layer #(.NUM_CHANNELS(2), .INPUT_DIM(5), .POOL_DIM(2), .DATA_SIZE(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .src_valid(b_valid),
        .src_idx_e(b_idx_e), .src_idx_y(b_idx_y), .src_idx_x(b_idx_x), .src_data(b_src_data),
        .rd_idx_e(b_rd_e), .rd_idx_y(b_rd_y), .rd_idx_x(b_rd_x), .rd_data(b_rd_data),
        .busy(b_busy), .done(b_done)
    );

    // Source memories answer one cycle after the index is presented.
    always @(posedge clk) begin
        a_src_data <= mem_a[4'(a_idx_y * 16'd4 + a_idx_x)];
        b_src_data <= mem_b[6'(b_idx_e * 16'd25 + b_idx_y * 16'd5 + b_idx_x)];
        if (b_busy && ((b_idx_y == 16'd4) || (b_idx_x == 16'd4))) b_edge_hit <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_a(input string tag, input int e, input int y, input int x, input real exp);
        a_rd_e = 16'(e);
        a_rd_y = 16'(y);
        a_rd_x = 16'(x);
        #1;
        check(tag, a_rd_data, $realtobits(exp));
    endtask

    task automatic read_b(input string tag, input int e, input int y, input int x, input real exp);
        b_rd_e = 16'(e);
        b_rd_y = 16'(y);
        b_rd_x = 16'(x);
        #1;
        check(tag, b_rd_data, $realtobits(exp));
    endtask

    task automatic run_a(output int l);
        @(negedge clk);
        a_start = 1'b1;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        l = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (a_done) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic leave_done_a();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic fill_ramp_a();
        for (int i = 0; i < 16; i++) mem_a[i] = $realtobits(real'(i));
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_rd_e = '0; a_rd_y = '0; a_rd_x = '0;
        b_start = 1'b0; b_valid = 1'b0; b_rd_e = '0; b_rd_y = '0; b_rd_x = '0;
        for (int i = 0; i < 16; i++) mem_a[i] = '0;
        for (int i = 0; i < 50; i++) mem_b[i] = '0;
        #12;
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_idx", {16'd0, a_idx_e, a_idx_y, a_idx_x}, 64'd0);
        read_a("rst_buf", 0, 1, 1, 0.0);
        @(negedge clk) rst_n = 1'b1;

        // start without src_valid is ignored
        @(negedge clk);
        a_start = 1'b1;
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("novalid_busy", 64'(a_busy), 64'd0);
        check("novalid_idx", {16'd0, a_idx_e, a_idx_y, a_idx_x}, 64'd0);
        a_start = 1'b0;

        // single-channel ramp
        fill_ramp_a();
        run_a(lat);
        check("ramp_latency", 64'(lat), 64'd37);
        check("ramp_busy_done", 64'(a_busy), 64'd0);
        read_a("ramp_00", 0, 0, 0, 5.0);
        read_a("ramp_01", 0, 0, 1, 7.0);
        read_a("ramp_10", 0, 1, 0, 13.0);
        read_a("ramp_11", 0, 1, 1, 15.0);
        read_a("oor_x7", 0, 0, 7, 0.0);
        read_a("oor_y2", 0, 2, 0, 0.0);
        read_a("oor_e1", 1, 0, 0, 0.0);

        // done holds while parked in DONE, clears right after start
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("done_hold", 64'(a_done), 64'd1);
        end
        leave_done_a();
        check("done_clear", 64'(a_done), 64'd0);
        check("idle_busy", 64'(a_busy), 64'd0);

        // all-negative data
        for (int i = 0; i < 16; i++) mem_a[i] = $realtobits(-3.0);
        mem_a[1] = $realtobits(-1.5);
        run_a(lat);
        check("neg_latency", 64'(lat), 64'd37);
        read_a("neg_00", 0, 0, 0, -1.5);
        read_a("neg_01", 0, 0, 1, -3.0);
        read_a("neg_10", 0, 1, 0, -3.0);
        read_a("neg_11", 0, 1, 1, -3.0);
        leave_done_a();

        // ties and NaN keep the current maximum
        fill_ramp_a();
        mem_a[0] = $realtobits(2.0);
        mem_a[1] = $realtobits(2.0);
        mem_a[4] = 64'h7FF8_0000_0000_0000;
        mem_a[5] = $realtobits(1.0);
        run_a(lat);
        check("nan_latency", 64'(lat), 64'd37);
        read_a("nan_tie_00", 0, 0, 0, 2.0);
        read_a("nan_other_11", 0, 1, 1, 15.0);
        read_a("nan_oor_x7", 0, 0, 7, 0.0);
        leave_done_a();

        // two channels, odd input size: row/col 4 must be skipped
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) begin
                real v;
                v = ((y == 4) || (x == 4)) ? 1000.0 : real'(y * 5 + x + 1);
                mem_b[y * 5 + x]      = $realtobits(v);
                mem_b[25 + y * 5 + x] = $realtobits(2.0 * v);
            end
        @(negedge clk);
        b_start = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (b_done) begin
                lat = k;
                break;
            end
        end
        check("odd_latency", 64'(lat), 64'd73);
        check("odd_edge_idx", 64'(b_edge_hit), 64'd0);
        read_b("odd_c0_00", 0, 0, 0, 7.0);
        read_b("odd_c0_01", 0, 0, 1, 9.0);
        read_b("odd_c0_10", 0, 1, 0, 17.0);
        read_b("odd_c0_11", 0, 1, 1, 19.0);
        read_b("odd_c1_00", 1, 0, 0, 14.0);
        read_b("odd_c1_01", 1, 0, 1, 18.0);
        read_b("odd_c1_10", 1, 1, 0, 34.0);
        read_b("odd_c1_11", 1, 1, 1, 38.0);
        read_b("odd_oor_y2", 0, 2, 0, 0.0);

        // reset in the middle of a pass
        fill_ramp_a();
        @(negedge clk);
        a_start = 1'b1;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_busy_before", 64'(a_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(a_busy), 64'd0);
        check("mid_rst_done", 64'(a_done), 64'd0);
        read_a("mid_rst_00", 0, 0, 0, 0.0);
        read_a("mid_rst_01", 0, 0, 1, 0.0);
        read_a("mid_rst_10", 0, 1, 0, 0.0);
        read_a("mid_rst_11", 0, 1, 1, 0.0);
        @(negedge clk) rst_n = 1'b1;
        run_a(lat);
        check("rerun_latency", 64'(lat), 64'd37);
        read_a("rerun_00", 0, 0, 0, 5.0);
        read_a("rerun_01", 0, 0, 1, 7.0);
        read_a("rerun_10", 0, 1, 0, 13.0);
        read_a("rerun_11", 0, 1, 1, 15.0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
